// File: rtl/outbox_pkg.sv
// Shared constants for the CPU mailbox blocks (outbox and inbox side).
package outbox_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int DEPTH_DEFAULT = 16;

    // Width of a word counter that can hold the value 'depth' itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/outbox_fifo_ram.sv
// Storage array for the outbox: DEPTH-1 entries, synchronous write, asynchronous read.
module fifo_ram
    import outbox_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // One slot fewer than DEPTH: the registered output stage holds the last word.
    logic [WIDTH-1:0] mem_q [0:DEPTH-2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/outbox.sv
// CPU-to-reader outbox FIFO: circular buffer plus one registered output stage.
//
// Handshake: oValid/oData are a valid/ready source. A word transfers on a rising
// edge where oValid=1 and iReady=1; while oValid=1 and iReady=0, oData and oValid
// hold. The CPU side pushes iR on wO=1 when oFull=0; a push while full is dropped
// and latches oOverflow.
module outbox
    import outbox_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         iR,
    input  logic                     wO,
    output logic                     oFull,
    output logic                     oEmpty,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic [WIDTH-1:0]         oData,
    output logic                     oValid,
    input  logic                     iReady,
    output logic                     oOverflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    logic             full;
    logic             push;
    logic             xfer;
    logic             mem_has_word;
    logic             load;
    logic [WIDTH-1:0] ram_rdata;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 2)) ? '0 : p + 1'b1;
    endfunction

    assign full         = (count_q == CW'(DEPTH));
    assign push         = wO && !full;
    assign xfer         = valid_q && iReady;
    // Words in the array = total count minus the one sitting in the output stage.
    assign mem_has_word = (count_q != CW'(valid_q));
    // Output stage only refills from the array, so a fresh push costs one extra edge.
    assign load         = mem_has_word && (!valid_q || xfer);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        count_d    = count_q + CW'(push) - CW'(xfer);

        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (load) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
            data_d   = ram_rdata;
            valid_d  = 1'b1;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        if (wO && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (iR),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign oFull     = full;
    assign oEmpty    = (count_q == '0);
    assign oCount    = count_q;
    assign oData     = data_q;
    assign oValid    = valid_q;
    assign oOverflow = overflow_q;

endmodule

// File: tb/tb_outbox.sv
// Self-checking bench for outbox: scoreboard queue fed on accepted pushes, drained on transfers.
module tb_outbox;

    localparam int W = 8;
    localparam int D = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [W-1:0]       iR;
    logic               wO;
    logic               oFull;
    logic               oEmpty;
    logic [$clog2(D):0] oCount;
    logic [W-1:0]       oData;
    logic               oValid;
    logic               iReady;
    logic               oOverflow;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic         hold_valid = 1'b0;
    logic [W-1:0] hold_data  = '0;

    outbox #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .iR        (iR),
        .wO        (wO),
        .oFull     (oFull),
        .oEmpty    (oEmpty),
        .oCount    (oCount),
        .oData     (oData),
        .oValid    (oValid),
        .iReady    (iReady),
        .oOverflow (oOverflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor (samples on falling edge) ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("hold_valid", {31'd0, oValid}, 32'd1);
                check("hold_data", {24'd0, oData}, {24'd0, hold_data});
            end
            if (wO && !oFull) exp_q.push_back(iR);
            if (oValid && iReady) begin
                if (exp_q.size() == 0) check("spurious_xfer", 32'd1, 32'd0);
                else check("fifo_order", {24'd0, oData}, {24'd0, exp_q.pop_front()});
            end
            hold_valid = oValid && !iReady;
            hold_data  = oData;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        step();
        wO = 1'b1;
        iR = w;
    endtask

    task automatic wait_empty(input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (oEmpty && exp_q.size() == 0) done = 1'b1;
        end
        check("drain_done", {31'd0, done}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b1; wO = 1'b0; iR = '0; iReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, oValid}, 32'd0);
        check("rst_data", {24'd0, oData}, 32'd0);
        check("rst_count", 32'(oCount), 32'd0);
        check("rst_empty", {31'd0, oEmpty}, 32'd1);
        check("rst_full", {31'd0, oFull}, 32'd0);
        check("rst_ovf", {31'd0, oOverflow}, 32'd0);

        // Single word: latency and hold with reader stalled.
        step();
        rst = 1'b0; wO = 1'b1; iR = 8'd3;
        step();
        wO = 1'b0;
        @(negedge clk);
        check("lat_not_yet", {31'd0, oValid}, 32'd0);
        check("lat_count", 32'(oCount), 32'd1);
        @(negedge clk);
        check("lat_valid", {31'd0, oValid}, 32'd1);
        check("lat_data", {24'd0, oData}, 32'd3);
        repeat (5) begin
            @(negedge clk);
            check("hold3_data", {24'd0, oData}, 32'd3);
            check("hold3_count", 32'(oCount), 32'd1);
        end
        step();
        iReady = 1'b1;
        wait_empty(10);

        // Back-to-back signed words with reader always ready.
        push_word(8'hFF);
        push_word(8'h05);
        push_word(8'h80);
        @(negedge clk);
        check("b2b_0", {24'd0, oData}, 32'hFF);
        step();
        wO = 1'b0;
        @(negedge clk);
        check("b2b_1", {24'd0, oData}, 32'h05);
        @(negedge clk);
        check("b2b_2", {24'd0, oData}, 32'h80);
        check("b2b_2v", {31'd0, oValid}, 32'd1);
        @(negedge clk);
        check("b2b_empty", {31'd0, oEmpty}, 32'd1);
        check("b2b_novalid", {31'd0, oValid}, 32'd0);

        // Fill to capacity, 17th push dropped.
        step();
        iReady = 1'b0;
        for (int i = 0; i <= 16; i++) push_word(W'(i));
        step();
        wO = 1'b0;
        @(negedge clk);
        check("full_flag", {31'd0, oFull}, 32'd1);
        check("full_count", 32'(oCount), 32'd16);
        check("full_ovf", {31'd0, oOverflow}, 32'd1);
        check("full_sb_size", 32'(exp_q.size()), 32'd16);

        // Push and transfer on the same edge while full.
        step();
        wO = 1'b1; iR = 8'd99; iReady = 1'b1;
        step();
        wO = 1'b0; iReady = 1'b0;
        @(negedge clk);
        check("fullx_count", 32'(oCount), 32'd15);
        check("fullx_full", {31'd0, oFull}, 32'd0);
        step();
        iReady = 1'b1;
        wait_empty(40);

        // Mid-operation reset, with wO/iReady active on the reset edge.
        step();
        iReady = 1'b0;
        for (int i = 0; i < 5; i++) push_word(W'(50 + i));
        step();
        wO = 1'b0;
        @(negedge clk);
        check("pre_rst_count", 32'(oCount), 32'd5);
        step();
        rst = 1'b1; wO = 1'b1; iR = 8'd77; iReady = 1'b1;
        step();
        rst = 1'b0; wO = 1'b1; iR = 8'd7; iReady = 1'b0;
        @(negedge clk);
        check("mrst_valid", {31'd0, oValid}, 32'd0);
        check("mrst_count", 32'(oCount), 32'd0);
        check("mrst_ovf", {31'd0, oOverflow}, 32'd0);
        check("mrst_data", {24'd0, oData}, 32'd0);
        step();
        wO = 1'b0;
        @(negedge clk);
        check("mrst_lat0", {31'd0, oValid}, 32'd0);
        @(negedge clk);
        check("mrst_lat1", {31'd0, oValid}, 32'd1);
        check("mrst_data7", {24'd0, oData}, 32'd7);
        step();
        iReady = 1'b1;
        wait_empty(10);

        // 40 words with random reader backpressure; pointers wrap repeatedly.
        n = 0;
        for (int c = 0; c < 2000 && n < 40; c++) begin
            step();
            iReady = 1'($urandom_range(0, 1));
            wO = !oFull && ($urandom_range(0, 3) != 0);
            iR = W'(n);
            if (wO) n++;
        end
        step();
        wO = 1'b0;
        iReady = 1'b1;
        check("rand_all_pushed", 32'(n), 32'd40);
        wait_empty(100);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        check("final_ovf", {31'd0, oOverflow}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/outbox.md
OUTBOX -- requirements
Module: outbox

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, total word capacity; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 iR  input  WIDTH  signed word from the CPU R register.
REQ-006 wO  input  1  CPU write strobe; pushes iR when oFull=0.
REQ-007 oFull  output  1  high when oCount==DEPTH; CPU stalls OUTBOX instruction while high.
REQ-008 oEmpty  output  1  high when oCount==0.
REQ-009 oCount  output  $clog2(DEPTH)+1  words held, including the word in the output stage.
REQ-010 oData  output  WIDTH  head word presented to the external reader.
REQ-011 oValid  output  1  oData holds a valid word.
REQ-012 iReady  input  1  external reader accepts oData; a transfer occurs on a rising edge with oValid=1 and iReady=1.
REQ-013 oOverflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-014 Storage: circular buffer of DEPTH-1 entries, write and read pointers of $clog2(DEPTH) bits, plus one registered output stage (oData/oValid), giving total capacity DEPTH.
REQ-015 Push accepted when wO=1 and oFull=0; accepted word stored unmodified, all WIDTH bits, sign preserved.
REQ-016 Push with wO=1 and oFull=1 dropped, no state change except oOverflow set to 1 on that edge.
REQ-017 Latency: word pushed into an empty OUTBOX at edge k drives oData with oValid=1 after edge k+1, not before.
REQ-018 Output stage refills on the same edge it is drained or empty, if storage holds a word; back-to-back transfers sustain one word per cycle with iReady held high.
REQ-019 oData and oValid held stable while oValid=1 and iReady=0.
REQ-020 Ordering strictly first-in first-out; no word duplicated or lost except per REQ-016.
REQ-021 oCount +1 on accepted push, -1 on transfer, unchanged when both occur on the same edge.
REQ-022 Simultaneous push and transfer when full (oFull=1): push dropped per REQ-016, transfer completes; new capacity usable on next edge.
REQ-023 Simultaneous push and transfer when oCount==1: both succeed; pushed word becomes valid on following edge per REQ-017.
REQ-024 Pointers wrap from DEPTH-2 to 0 without disturbing data.
REQ-025 oFull, oEmpty, oCount driven from registered state only, no combinational path from wO or iReady.
REQ-026 oData value while oValid=0 is don't-care for readers; SHALL NOT be X after reset (holds 0).

Reset
REQ-027 rst=1 at a rising edge: pointers 0, oCount 0, oValid 0, oData 0, oOverflow 0, oEmpty 1, oFull 0.
REQ-028 rst mid-operation flushes all stored words; wO and iReady ignored on the reset edge.
REQ-029 Storage array contents need not be cleared.

Structure
REQ-030 Shared package/include holds WIDTH default (8) and DEPTH default (16) constants, shared with the inbox side.
REQ-031 One sub-module, fifo_ram: DEPTH-1 x WIDTH storage, one synchronous write port, one asynchronous read port; pointer/count/output-stage control stays in outbox.

Verification
REQ-032 Reset, push 8'sd3 at edge 1, iReady=0 -> oValid=1, oData=3 after edge 2; oData holds 3 for 5 cycles; oCount=1.
REQ-033 Push -1, 5, -128 back-to-back, iReady=1 from start -> reader receives 8'hFF, 8'h05, 8'h80 on three consecutive edges; oEmpty=1 after.
REQ-034 iReady=0, push 17 words 0..16 -> oFull=1 after 16th push, 17th dropped, oOverflow=1, oCount=16; draining yields 0..15.
REQ-035 When full, wO=1 and iReady=1 same edge -> push dropped, transfer of word 0, oCount=15, oFull=0 next cycle.
REQ-036 Push 40 words with random iReady -> output order 0..39, pointers wrap twice, no loss.
REQ-037 oCount=5, assert rst one cycle -> oValid=0, oCount=0, oOverflow=0 next cycle; subsequent push 8'sd7 appears per REQ-017.
